// File: rtl/cube_feeder.sv
// cube_feeder: operand FIFO and launch sequencer in front of the sequential
// 8-bit cube-root unit. Operands arrive on a valid/ready stream, are launched
// one at a time, and each root leaves paired with its operand on a valid/ready
// result stream, in arrival order.
// Optional feature macro: CUBE_FEEDER_TIMEOUT_EN adds a watchdog that aborts a
// launch whose busy handshake does not complete within TIMEOUT cycles.
module cube_feeder #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  output logic       in_ready_o,
  output logic       cu_start_o,
  output logic [7:0] cu_x_o,
  input  logic       cu_busy_i,
  input  logic [7:0] cu_y_i,
  output logic       out_valid_o,
  output logic [7:0] out_x_o,
  output logic [7:0] out_data_o,
  output logic       out_err_o,
  input  logic       out_ready_i
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_HI,
    S_WAIT_LO,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [7:0]  r_cu_x;
  logic        r_out_valid;
  logic [7:0]  r_out_x;
  logic [7:0]  r_out_data;
  logic        r_out_err;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_load;
  logic        w_wd_hit;
  logic        w_err_now;

  // Same index bits with different wrap bits means the write side is a full lap ahead.
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_push  = in_valid_i && !w_full;

`ifdef CUBE_FEEDER_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_wd_cnt;
  logic       r_abort;

  assign w_wd_hit  = (r_wd_cnt == WD_LAST);
  assign w_err_now = r_abort;

  // Watchdog: cleared as the FSM heads into LAUNCH, counts while waiting on busy.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wd_cnt <= '0;
      r_abort  <= 1'b0;
    end else if (w_pop) begin
      r_wd_cnt <= '0;
      r_abort  <= 1'b0;
    end else if (r_state == S_WAIT_HI || r_state == S_WAIT_LO) begin
      r_wd_cnt <= r_wd_cnt + 8'd1;
      if (w_wd_hit) r_abort <= 1'b1;
    end
  end
`else
  assign w_wd_hit  = 1'b0;
  assign w_err_now = 1'b0;
`endif

  // FSM state register.
  // NOTE: every clocked block uses <= so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and handshake strobes.
  // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latch).
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Also waiting for !busy keeps a late busy fall after an abort harmless.
        if (!w_empty && !cu_busy_i) begin
          w_pop  = 1'b1;
          w_next = S_LAUNCH;
        end
      end
      S_LAUNCH:  w_next = S_WAIT_HI;
      S_WAIT_HI: begin
        if (w_wd_hit)       w_next = S_DONE;
        else if (cu_busy_i) w_next = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (w_wd_hit || !cu_busy_i) w_next = S_DONE;
      end
      S_DONE: begin
        // The unit's result stays stable here because nothing new is launched.
        if (!r_out_valid || out_ready_i) begin
          w_load = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand storage.
  // NOTE: the array has no reset; empty/full come from the pointers alone.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= in_data_i;
  end

  // FIFO pointers; wrap by natural overflow of the extra MSB.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Operand to the unit: captured at pop, held until the next launch.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)     r_cu_x <= '0;
    else if (w_pop) r_cu_x <= r_mem[r_rd_ptr[AW-1:0]];
  end

  // Result register: load from DONE, drop valid on a transfer with no new load.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_out_valid <= 1'b0;
      r_out_x     <= '0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_x     <= r_cu_x;
      r_out_data  <= w_err_now ? 8'hFF : cu_y_i;
      r_out_err   <= w_err_now;
    end else if (r_out_valid && out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready_o  = !w_full;
  assign cu_start_o  = (r_state == S_LAUNCH);
  assign cu_x_o      = r_cu_x;
  assign out_valid_o = r_out_valid;
  assign out_x_o     = r_out_x;
  assign out_data_o  = r_out_data;
  assign out_err_o   = r_out_err;

endmodule
